// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD widths, month bounds and month-length class encoding
package clock_pkg;
    localparam int UNIT_W = 4;
    localparam int TEN_W = 1;
    localparam logic [7:0] MONTH_MIN = 8'h01;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam int DEC_TEN = 1;
    localparam int DEC_UNIT = 2;
    typedef enum logic [1:0] {
        LEN_NONE,
        LEN_31,
        LEN_30,
        LEN_FEB
    } month_len_e;
endpackage

// File: rtl/month_len_decode.sv
// month_len_decode: BCD month -> 31/30/February class flags plus validity
module month_len_decode
    import clock_pkg::*;
#(
    parameter int UW = UNIT_W,
    parameter int TW = TEN_W
) (
    input  logic [TW-1:0] i_ten,
    input  logic [UW-1:0] i_unit,
    output logic          o_to,
    output logic          o_t,
    output logic          o_tn,
    output logic          o_valid
);
    logic       w_lo;
    logic       w_hi;
    month_len_e w_class;
    // 01..09 and 10..12 are the only legal codes; anything else reports no class
    always_comb begin
        w_lo    = (i_ten == '0) && (i_unit != '0) && (i_unit <= UW'(9));
        w_hi    = (i_ten == TW'(DEC_TEN)) && (i_unit <= UW'(DEC_UNIT));
        o_valid = w_lo | w_hi;
        w_class = !o_valid ? LEN_NONE :
                  w_hi ? ((i_unit == UW'(1)) ? LEN_30 : LEN_31) :
                  (i_unit == UW'(2)) ? LEN_FEB :
                  ((i_unit == UW'(4)) || (i_unit == UW'(6)) || (i_unit == UW'(9))) ? LEN_30 :
                  LEN_31;
        o_to    = (w_class == LEN_31);
        o_t     = (w_class == LEN_30);
        o_tn    = (w_class == LEN_FEB);
    end
endmodule

// File: rtl/count_month.sv
// count_month: BCD month counter 01..12 with length-class flags and year pulse
module count_month
    import clock_pkg::*;
#(
    parameter int MAX_DISPLAY_UNIT = UNIT_W,
    parameter int MAX_DISPLAY_TEN  = TEN_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_m,
    input  logic                        up,
    input  logic                        down,
    output logic [MAX_DISPLAY_UNIT-1:0] month_unit,
    output logic [MAX_DISPLAY_TEN-1:0]  month_ten,
    output logic                        TO,
    output logic                        T,
    output logic                        TN,
    output logic                        pulse_m
);
    localparam logic [MAX_DISPLAY_TEN-1:0]  MIN_TEN  = MAX_DISPLAY_TEN'(MONTH_MIN[7:4]);
    localparam logic [MAX_DISPLAY_UNIT-1:0] MIN_UNIT = MAX_DISPLAY_UNIT'(MONTH_MIN[3:0]);
    localparam logic [MAX_DISPLAY_TEN-1:0]  MAX_TEN  = MAX_DISPLAY_TEN'(MONTH_MAX[7:4]);
    localparam logic [MAX_DISPLAY_UNIT-1:0] MAX_UNIT = MAX_DISPLAY_UNIT'(MONTH_MAX[3:0]);
    localparam logic [MAX_DISPLAY_UNIT-1:0] NINE     = MAX_DISPLAY_UNIT'(9);

    logic [MAX_DISPLAY_TEN-1:0]  r_month_ten;
    logic [MAX_DISPLAY_UNIT-1:0] r_month_unit;
    logic [MAX_DISPLAY_TEN-1:0]  w_ten_inc, w_ten_dec, w_ten_nxt;
    logic [MAX_DISPLAY_UNIT-1:0] w_unit_inc, w_unit_dec, w_unit_nxt;
    logic                        w_valid, w_is_max, w_is_min, w_inc, w_dec;

    month_len_decode #(
        .UW(MAX_DISPLAY_UNIT),
        .TW(MAX_DISPLAY_TEN)
    ) u_decode (
        .i_ten  (r_month_ten),
        .i_unit (r_month_unit),
        .o_to   (TO),
        .o_t    (T),
        .o_tn   (TN),
        .o_valid(w_valid)
    );

    // per-digit BCD increment/decrement with explicit carry/borrow and 12<->01 wrap
    always_comb begin
        w_is_max   = (r_month_ten == MAX_TEN) && (r_month_unit == MAX_UNIT);
        w_is_min   = (r_month_ten == MIN_TEN) && (r_month_unit == MIN_UNIT);
        w_ten_inc  = w_is_max ? MIN_TEN : (r_month_unit == NINE) ? r_month_ten + MAX_DISPLAY_TEN'(1) : r_month_ten;
        w_unit_inc = w_is_max ? MIN_UNIT : (r_month_unit == NINE) ? '0 : r_month_unit + MAX_DISPLAY_UNIT'(1);
        w_ten_dec  = w_is_min ? MAX_TEN : (r_month_unit == '0) ? r_month_ten - MAX_DISPLAY_TEN'(1) : r_month_ten;
        w_unit_dec = w_is_min ? MAX_UNIT : (r_month_unit == '0) ? NINE : r_month_unit - MAX_DISPLAY_UNIT'(1);
        w_inc      = en_m | (up & ~down);
        w_dec      = ~en_m & down & ~up;
        w_ten_nxt  = !w_valid ? MIN_TEN : w_inc ? w_ten_inc : w_dec ? w_ten_dec : r_month_ten;
        w_unit_nxt = !w_valid ? MIN_UNIT : w_inc ? w_unit_inc : w_dec ? w_unit_dec : r_month_unit;
    end

    // month register; an illegal code falls back to 01 on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_month_ten  <= MIN_TEN;
            r_month_unit <= MIN_UNIT;
        end else begin
            r_month_ten  <= w_ten_nxt;
            r_month_unit <= w_unit_nxt;
        end
    end

    assign month_ten  = r_month_ten;
    assign month_unit = r_month_unit;
    assign pulse_m    = en_m & ~rst & w_valid & w_is_max;
endmodule
